// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS lightweight-bridge PIO blocks:
// the word-address register map and the edge-capture selection.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET      = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // True when a debounced transition is one the capture register should latch.
  function automatic logic edge_hit(input int edge_type, input logic rise, input logic fall);
    logic hit;
    case (edge_type)
      EDGE_RISING:  hit = rise;
      EDGE_FALLING: hit = fall;
      EDGE_ANY:     hit = rise | fall;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input bit: 2-FF synchronizer, persistence counter and debounced level.
// rise/fall are combinational and fire on the cycle the debounced level updates.
module soc_system_pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic [CW-1:0] count_r;
  logic          done_s;

  // The synchronized level has differed long enough to be accepted this clock.
  assign done_s = (sync2_r != stable_r) && (count_r == CW'(DEBOUNCE_CYCLES - 1));

  // Synchronizer, persistence counter and debounced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r  <= IDLE_LEVEL;
      sync2_r  <= IDLE_LEVEL;
      stable_r <= IDLE_LEVEL;
      count_r  <= '0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        count_r <= '0;
      end else if (done_s) begin
        stable_r <= sync2_r;
        count_r  <= '0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  assign stable = stable_r;
  assign rise   = done_s & sync2_r;
  assign fall   = done_s & ~sync2_r;

endmodule

// File: rtl/soc_system_key_pio.sv
// Avalon-MM input PIO for push-buttons/switches: debounced DATA, IRQ mask,
// RW1C edge capture and a level interrupt, read latency 1.
module soc_system_key_pio
  import soc_system_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = EDGE_FALLING,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [31:0]      rd_s;
  logic             wr_s;
  logic             unused_s;

  assign wr_s     = chipselect & ~write_n;
  assign unused_s = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .stable  (stable_s[i]),
      .rise    (rise_s[i]),
      .fall    (fall_s[i])
    );
  end

  // Per-bit capture request for transitions of the configured polarity.
  always_comb begin
    set_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      set_s[i] = edge_hit(EDGE_TYPE, rise_s[i], fall_s[i]);
    end
  end

  // Write-one-to-clear mask for the edge-capture register.
  always_comb begin
    clr_s = '0;
    if (wr_s && (address == ADDR_EDGECAPTURE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
  end

  // Read mux; unimplemented addresses and upper bits read as zero.
  always_comb begin
    rd_s = 32'h0;
    case (address)
      ADDR_DATA:        rd_s[WIDTH-1:0] = stable_s;
      ADDR_IRQMASK:     rd_s[WIDTH-1:0] = irqmask_r;
      ADDR_EDGECAPTURE: rd_s[WIDTH-1:0] = edgecap_r;
      default:          rd_s = 32'h0;
    endcase
  end

  // Register file and registered read data; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_r <= '0;
      edgecap_r <= '0;
      readdata  <= 32'h0;
    end else begin
      readdata  <= rd_s;
      edgecap_r <= (edgecap_r & ~clr_s) | set_s;
      if (wr_s && (address == ADDR_IRQMASK)) begin
        irqmask_r <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_soc_system_key_pio.sv
// Self-checking bench: directed scenarios plus randomized inputs and bus
// traffic, compared every cycle against a sliding-window reference model.
`timescale 1ns/1ps
module tb_soc_system_key_pio;

  localparam int W  = 4;
  localparam int DC = 4;
  localparam int ET = 1;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [2:0]    address    = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'h0;
  logic [W-1:0]  in_port    = 4'hF;
  logic [31:0]   readdata;
  logic          irq;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  soc_system_key_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(ET), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last DC synchronized
  // samples all agree and differ from the accepted level.
  bit [W-1:0]  m_s1, m_stable, m_mask, m_ecap;
  bit [W-1:0]  m_win [DC];
  logic [31:0] m_rd;
  bit [W-1:0]  nx_stable, nx_set, nx_clr, nx_mask;
  logic [31:0] nx_rd;
  bit          win_same;

  always_comb begin
    nx_stable = m_stable;
    win_same  = 1'b1;
    for (int b = 0; b < W; b++) begin
      win_same = 1'b1;
      for (int k = 1; k < DC; k++) if (m_win[k][b] != m_win[0][b]) win_same = 1'b0;
      if (win_same && (m_win[0][b] != m_stable[b])) nx_stable[b] = m_win[0][b];
    end
    nx_set = (ET == 0) ? (nx_stable & ~m_stable) :
             (ET == 1) ? (~nx_stable & m_stable) : (nx_stable ^ m_stable);
    case (address)
      3'd0:    nx_rd = {28'h0, m_stable};
      3'd2:    nx_rd = {28'h0, m_mask};
      3'd3:    nx_rd = {28'h0, m_ecap};
      default: nx_rd = 32'h0;
    endcase
    nx_clr  = '0;
    nx_mask = m_mask;
    if (chipselect && !write_n && address == 3'd2) nx_mask = writedata[W-1:0];
    if (chipselect && !write_n && address == 3'd3) nx_clr  = writedata[W-1:0];
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '1; m_stable <= '1; m_mask <= '0; m_ecap <= '0; m_rd <= 32'h0;
      for (int k = 0; k < DC; k++) m_win[k] <= '1;
    end else begin
      m_rd     <= nx_rd;
      m_mask   <= nx_mask;
      m_ecap   <= (m_ecap & ~nx_clr) | nx_set;
      m_stable <= nx_stable;
      for (int k = 0; k < DC - 1; k++) m_win[k] <= m_win[k+1];
      m_win[DC-1] <= m_s1;
      m_s1 <= in_port;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("cyc_readdata", readdata, m_rd);
      check("cyc_irq", {31'h0, irq}, {31'h0, |(m_ecap & m_mask)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1;
    tick();
    chipselect = 1'b0;
    check(tag, readdata, exp);
  endtask

  int b;

  initial begin
    #12 reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Reset state
    read_check("rst_data", 3'd0, 32'hF);
    read_check("rst_ecap", 3'd3, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // Falling edge on bit 2: accepted exactly DC+1 edges after sampling
    address = 3'd0; in_port[2] = 1'b0;
    repeat (6) tick();
    check("fall_data_early", readdata, 32'hF);
    tick();
    check("fall_data", readdata, 32'hB);
    read_check("fall_ecap", 3'd3, 32'h4);
    check("fall_irq_masked", {31'h0, irq}, 32'h0);
    bus_write(3'd2, 32'h4);
    check("mask_irq", {31'h0, irq}, 32'h1);

    // Bounce on bit 1 never persists long enough
    address = 3'd0; in_port[1] = 1'b0;
    repeat (3) tick();
    in_port[1] = 1'b1; tick();
    in_port[1] = 1'b0; repeat (2) tick();
    in_port[1] = 1'b1; repeat (8) tick();
    check("bounce_data", readdata, 32'hB);
    read_check("bounce_ecap", 3'd3, 32'h4);

    // RW1C on the same edge bit 0 completes its falling debounce: set wins
    in_port[0] = 1'b0;
    repeat (5) tick();
    bus_write(3'd3, 32'h5);
    check("clr_irq_mask4", {31'h0, irq}, 32'h0);
    read_check("clr_ecap", 3'd3, 32'h1);
    bus_write(3'd2, 32'h5);
    check("mask5_irq", {31'h0, irq}, 32'h1);
    bus_write(3'd2, 32'h4);
    check("mask4_irq", {31'h0, irq}, 32'h0);

    // Rising edge is not captured; unused addresses read 0 and ignore writes
    in_port[2] = 1'b1;
    repeat (8) tick();
    read_check("rise_data", 3'd0, 32'hE);
    read_check("rise_ecap", 3'd3, 32'h1);
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'hFFFF_FFFF);
    read_check("dir_zero", 3'd1, 32'h0);
    read_check("a4_zero", 3'd4, 32'h0);
    read_check("a5_zero", 3'd5, 32'h0);
    read_check("a6_zero", 3'd6, 32'h0);
    read_check("mask_keep", 3'd2, 32'h4);
    read_check("ecap_keep", 3'd3, 32'h1);
    read_check("data_keep", 3'd0, 32'hE);

    // Reset mid-debounce discards the partial count
    address = 3'd0; in_port[3] = 1'b0;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_rd", readdata, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) tick();
    check("rerun_early", readdata, 32'hF);
    tick();
    check("rerun_data", readdata, 32'h6);
    read_check("rerun_ecap", 3'd3, 32'h9);
    read_check("rerun_mask", 3'd2, 32'h0);

    // Randomized inputs and bus traffic, checked each cycle by the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, W - 1);
        in_port[b] = ~in_port[b];
      end
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = $urandom;
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
